cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Cook-cycle controller for the microwave's heating PWM generator. Accepts a cook time and heating level from the keypad/UI logic, runs a seconds countdown, and drives the generator's enable, master-enable and heating-level inputs. Handles pause/resume, cancel and the door-open interlock, and raises a timed completion beep. Sits between the UI front end and the PWM generator, clocked from the same system clock.

## Interface

**Parameters**
- `TICK_CYCLES`, default 50000000: clock cycles per 1 s countdown tick. Benches override it to a small value.
- `BEEP_SECONDS`, default 3: number of ticks `beep` stays high in DONE.
- `TIME_BITS`, default 12: width of the time fields, giving a maximum of 4095 s.

**Ports**
- `clock`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: one-cycle pulse. Starts from IDLE or resumes from PAUSED.
- `pause`, input, 1: one-cycle pulse. Pauses COOKING.
- `cancel`, input, 1: one-cycle pulse. Aborts from any state.
- `door_open`, input, 1: level. Safety interlock.
- `time_in`, input, TIME_BITS: requested cook time in seconds. Sampled on an accepted start from IDLE.
- `level_in`, input, 2: requested heating level (00 low, 01 medium, 10 normal, 11 high). Sampled with `time_in`.
- `pwm_enable`, output, 1: generator enable.
- `master_enable`, output, 1: generator master enable.
- `heating_level`, output, 2: latched level to the generator.
- `seconds_left`, output, TIME_BITS: remaining cook time.
- `state`, output, 2: current state. 00 IDLE, 01 COOKING, 10 PAUSED, 11 DONE.
- `beep`, output, 1: completion buzzer.

## Operation

**Input priority, evaluated each cycle:** cancel > door_open > pause > start.

**Reset and cancel**
- Reset applies in any state. Cancel applies in any state.
- Both force IDLE and clear `seconds_left`, the prescaler and the beep counter.
- `heating_level` goes to 10 on both.

**IDLE**
- `start` with `door_open`=0 and `time_in`≠0: latch `time_in` into `seconds_left`, latch `level_in` into `heating_level`, clear the prescaler, go to COOKING.
- `start` with `time_in`=0 or `door_open`=1 is ignored.

**COOKING**
- `pwm_enable`=1 and `master_enable`=1 only in this state.
- The prescaler counts 0..TICK_CYCLES-1 and wraps. Wrap is the tick.
- On a tick, `seconds_left` decrements.
- If the tick takes `seconds_left` from 1 to 0, go to DONE on the same edge and clear the prescaler.
- `door_open` or `pause` goes to PAUSED. The prescaler value is held, not cleared.

**PAUSED**
- `pwm_enable`=0 and `master_enable`=0. `seconds_left` is frozen.
- `start` with `door_open`=0 returns to COOKING. The prescaler resumes from the held value.
- `start` while `door_open`=1 is ignored.
- `time_in` and `level_in` are not re-sampled on resume.

**DONE**
- `beep`=1.
- The prescaler runs. After BEEP_SECONDS ticks, go to IDLE with `beep`=0.
- `start` and `pause` are ignored. `cancel` ends the beep immediately.
- `door_open` does not affect the beep.

**Widths**
- The prescaler is $clog2(TICK_CYCLES) bits.
- The beep counter is $clog2(BEEP_SECONDS+1) bits.
- `seconds_left` never underflows. No decrement occurs at 0.

## Timing

- All outputs are registered. Each output reflects the inputs sampled on the previous rising edge, giving 1-cycle latency from a pulse to the state or output change.
- **Reset values:**
  - `state`=IDLE
  - `seconds_left`=0
  - `heating_level`=10
  - `pwm_enable`=0
  - `master_enable`=0
  - `beep`=0
- **Cook duration:** from the accepted start edge to entry into DONE is exactly N·TICK_CYCLES cycles for `time_in`=N with no pause.
- **Pause accounting:** pauses add their duration exactly. No partial tick is lost or repeated.
- **Same-cycle events:**
  - `door_open` rising in the same cycle as a tick: enter PAUSED, and the decrement is applied.
  - `cancel` in the same cycle as a tick: IDLE wins, and `seconds_left` ends at 0.
- **Door interlock:** heating outputs drop 1 cycle after `door_open` rises.
- **Mid-operation reset:** reset asserted mid-COOKING gives all outputs at their reset values on the next edge.

## Test plan

All scenarios use TICK_CYCLES=10 and BEEP_SECONDS=2.

1. **Normal cook.** `time_in`=3, `level_in`=11, `start`.
   - Required: COOKING with `heating_level`=11, enables high for 30 cycles, `seconds_left` 3→2→1→0.
   - Required: DONE with `beep` high for 20 cycles, then IDLE.
2. **Pause and resume.** `time_in`=2. Pause at prescaler=4, hold 50 cycles, then `start`.
   - Required: total enabled cycles = 20, DONE 1 cycle after the 20th enabled cycle, `seconds_left` frozen while paused.
3. **Door interlock.**
   - Assert `door_open` mid-COOKING. Required: enables drop next cycle and state=PAUSED.
   - Pulse `start` while the door is still open. Required: state stays PAUSED.
   - Close the door, then pulse `start`. Required: COOKING resumes.
4. **Rejected starts.** Pulse `start` with `time_in`=0; pulse `start` with `door_open`=1.
   - Required: state remains IDLE and enables stay 0.
5. **Cancel and reset.** Cancel during COOKING at `seconds_left`=5, then during DONE while beeping.
   - Required: next cycle IDLE, `seconds_left`=0, `beep`=0.
   - Assert reset mid-cook. Required: all outputs at their reset values.
6. **Same-cycle collisions.**
   - `cancel` together with `start` from IDLE. Required: stays IDLE.
   - `pause` on a tick cycle. Required: PAUSED, and the decrement is applied.

Source files
------------

// File: rtl/cook_sequencer.sv
// Cook-cycle controller for the microwave heating PWM generator: seconds countdown,
// pause/resume, cancel, door interlock and a timed completion beep.
module cook_sequencer #(
    parameter int TICK_CYCLES  = 50000000,
    parameter int BEEP_SECONDS = 3,
    parameter int TIME_BITS    = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 cancel,
    input  logic                 door_open,
    input  logic [TIME_BITS-1:0] time_in,
    input  logic [1:0]           level_in,
    output logic                 pwm_enable,
    output logic                 master_enable,
    output logic [1:0]           heating_level,
    output logic [TIME_BITS-1:0] seconds_left,
    output logic [1:0]           state,
    output logic                 beep
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COOKING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BEEP_W = (BEEP_SECONDS > 0) ? $clog2(BEEP_SECONDS + 1) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST      = PRE_W'(TICK_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST     = BEEP_W'(BEEP_SECONDS - 1);
    localparam logic [1:0]        LEVEL_DEFAULT = 2'b10;

    state_t             cur_state;
    logic [PRE_W-1:0]   prescaler;
    logic [PRE_W-1:0]   prescaler_next;
    logic [BEEP_W-1:0]  beep_count;
    logic               tick;

    assign state          = cur_state;
    assign tick           = (prescaler == PRE_LAST);
    assign prescaler_next = tick ? '0 : prescaler + PRE_W'(1);

    always_ff @(posedge clock) begin
        // NOTE: these non-blocking defaults are overridden by any later assignment in
        // the same block, so every branch only states where the outputs go high.
        pwm_enable    <= 1'b0;
        master_enable <= 1'b0;
        beep          <= 1'b0;

        if (reset || cancel) begin
            cur_state     <= IDLE;
            seconds_left  <= '0;
            prescaler     <= '0;
            beep_count    <= '0;
            heating_level <= LEVEL_DEFAULT;
        end else begin
            unique case (cur_state)
                IDLE: begin
                    // A pending pause or an open door outranks start.
                    if (start && !pause && !door_open && (time_in != '0)) begin
                        cur_state     <= COOKING;
                        seconds_left  <= time_in;
                        heating_level <= level_in;
                        prescaler     <= '0;
                        pwm_enable    <= 1'b1;
                        master_enable <= 1'b1;
                    end
                end

                COOKING: begin
                    // The current cycle is cooking time, so the prescaler advances even
                    // when leaving for PAUSED; that keeps pause accounting exact.
                    prescaler <= prescaler_next;
                    if (tick && (seconds_left != '0)) begin
                        seconds_left <= seconds_left - TIME_BITS'(1);
                    end

                    // The final tick completes the cook even if a pause arrives with it.
                    if (tick && (seconds_left == TIME_BITS'(1))) begin
                        cur_state  <= DONE;
                        prescaler  <= '0;
                        beep_count <= '0;
                        beep       <= 1'b1;
                    end else if (door_open || pause) begin
                        cur_state <= PAUSED;
                    end else begin
                        pwm_enable    <= 1'b1;
                        master_enable <= 1'b1;
                    end
                end

                PAUSED: begin
                    if (start && !pause && !door_open) begin
                        cur_state     <= COOKING;
                        pwm_enable    <= 1'b1;
                        master_enable <= 1'b1;
                    end
                end

                DONE: begin
                    prescaler <= prescaler_next;
                    if (tick && (beep_count == BEEP_LAST)) begin
                        cur_state  <= IDLE;
                        beep_count <= '0;
                    end else begin
                        if (tick) begin
                            beep_count <= beep_count + BEEP_W'(1);
                        end
                        beep <= 1'b1;
                    end
                end

                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios plus random pulses, every cycle compared
// against a model that tracks elapsed cooking time in cycles.
module tb_cook_sequencer;

    localparam int TICK  = 10;
    localparam int BEEPS = 2;
    localparam int TB    = 12;

    localparam int S_IDLE    = 0;
    localparam int S_COOKING = 1;
    localparam int S_PAUSED  = 2;
    localparam int S_DONE    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          pause;
    logic          cancel;
    logic          door_open;
    logic [TB-1:0] time_in;
    logic [1:0]    level_in;
    logic          pwm_enable;
    logic          master_enable;
    logic [1:0]    heating_level;
    logic [TB-1:0] seconds_left;
    logic [1:0]    state;
    logic          beep;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles;
    int beep_cycles;

    // Model: cook length in seconds, cooking cycles elapsed, DONE cycles elapsed.
    int         m_state   = S_IDLE;
    int         m_n       = 0;
    int         m_elapsed = 0;
    int         m_beep    = 0;
    logic [1:0] m_level   = 2'b10;

    cook_sequencer #(
        .TICK_CYCLES  (TICK),
        .BEEP_SECONDS (BEEPS),
        .TIME_BITS    (TB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .pause         (pause),
        .cancel        (cancel),
        .door_open     (door_open),
        .time_in       (time_in),
        .level_in      (level_in),
        .pwm_enable    (pwm_enable),
        .master_enable (master_enable),
        .heating_level (heating_level),
        .seconds_left  (seconds_left),
        .state         (state),
        .beep          (beep)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (reset || cancel) begin
            m_state = S_IDLE; m_n = 0; m_elapsed = 0; m_beep = 0; m_level = 2'b10;
        end else begin
            case (m_state)
                S_IDLE:
                    if (start && !pause && !door_open && time_in != 0) begin
                        m_state = S_COOKING; m_n = int'(time_in); m_elapsed = 0;
                        m_level = level_in;
                    end
                S_COOKING: begin
                    m_elapsed++;
                    if (m_elapsed == m_n * TICK) begin
                        m_state = S_DONE; m_beep = 0;
                    end else if (door_open || pause) begin
                        m_state = S_PAUSED;
                    end
                end
                S_PAUSED:
                    if (start && !pause && !door_open) m_state = S_COOKING;
                default: begin
                    m_beep++;
                    if (m_beep == BEEPS * TICK) m_state = S_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("seconds_left", seconds_left, m_n - m_elapsed / TICK);
        check("heating_level", heating_level, m_level);
        check("pwm_enable", pwm_enable, m_state == S_COOKING);
        check("master_enable", master_enable, m_state == S_COOKING);
        check("beep", beep, m_state == S_DONE);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_update();
        #1;
        compare_all();
        if (pwm_enable === 1'b1) en_cycles++;
        if (beep === 1'b1) beep_cycles++;
        start = 1'b0; pause = 1'b0; cancel = 1'b0; reset = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && state !== target; i++) cyc();
        check(tag, state, target);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; cancel = 1'b0; door_open = 1'b0;
        time_in = '0; level_in = 2'b00;
        en_cycles = 0; beep_cycles = 0;
        cyc();
        check("reset_state", state, S_IDLE);
        check("reset_level", heating_level, 2'b10);

        // Normal cook: 3 s at high level.
        time_in = 3; level_in = 2'b11; en_cycles = 0; beep_cycles = 0;
        start = 1'b1; cyc();
        check("t1_level", heating_level, 2'b11);
        repeat (60) cyc();
        check("t1_enabled_cycles", en_cycles, 30);
        check("t1_beep_cycles", beep_cycles, 20);
        check("t1_final_idle", state, S_IDLE);

        // Pause after four cooking cycles, hold 50, resume.
        time_in = 2; level_in = 2'b01; en_cycles = 0;
        start = 1'b1; cyc();
        repeat (4) cyc();
        pause = 1'b1; cyc();
        repeat (50) cyc();
        check("t2_frozen_seconds", seconds_left, 2);
        check("t2_paused", state, S_PAUSED);
        start = 1'b1; cyc();
        wait_state(2'(S_DONE), 40, "t2_reach_done");
        check("t2_enabled_cycles", en_cycles, 20);
        wait_state(2'(S_IDLE), 30, "t2_reach_idle");

        // Door interlock.
        time_in = 5; start = 1'b1; cyc();
        repeat (13) cyc();
        door_open = 1'b1; cyc();
        check("t3_door_paused", state, S_PAUSED);
        check("t3_door_pwm_off", pwm_enable, 1'b0);
        start = 1'b1; cyc();
        check("t3_start_door_open", state, S_PAUSED);
        door_open = 1'b0; cyc();
        start = 1'b1; cyc();
        check("t3_resumed", state, S_COOKING);
        check("t3_resumed_pwm", pwm_enable, 1'b1);
        cancel = 1'b1; cyc();

        // Rejected starts.
        time_in = 0; start = 1'b1; cyc();
        check("t4_zero_time", state, S_IDLE);
        time_in = 4; door_open = 1'b1; start = 1'b1; cyc();
        check("t4_door_open", state, S_IDLE);
        check("t4_pwm_off", pwm_enable, 1'b0);
        door_open = 1'b0; cyc();

        // Cancel while cooking and while beeping, then reset mid-cook.
        time_in = 7; start = 1'b1; cyc();
        repeat (20) cyc();
        check("t5_seconds_at_5", seconds_left, 5);
        cancel = 1'b1; cyc();
        check("t5_cancel_idle", state, S_IDLE);
        check("t5_cancel_seconds", seconds_left, 0);
        time_in = 1; start = 1'b1; cyc();
        wait_state(2'(S_DONE), 20, "t5_reach_done");
        repeat (5) cyc();
        check("t5_beeping", beep, 1'b1);
        cancel = 1'b1; cyc();
        check("t5_cancel_beep", beep, 1'b0);
        time_in = 9; level_in = 2'b00; start = 1'b1; cyc();
        repeat (15) cyc();
        reset = 1'b1; cyc();
        check("t5_reset_state", state, S_IDLE);
        check("t5_reset_seconds", seconds_left, 0);
        check("t5_reset_level", heating_level, 2'b10);
        check("t5_reset_pwm", pwm_enable, 1'b0);

        // Same-cycle collisions.
        time_in = 5; cancel = 1'b1; start = 1'b1; cyc();
        check("t6_cancel_start", state, S_IDLE);
        time_in = 3; start = 1'b1; cyc();
        repeat (9) cyc();
        pause = 1'b1; cyc();
        check("t6_pause_tick_state", state, S_PAUSED);
        check("t6_pause_tick_seconds", seconds_left, 2);
        start = 1'b1; cyc();
        wait_state(2'(S_DONE), 30, "t6_reach_done");
        wait_state(2'(S_IDLE), 30, "t6_reach_idle");

        // Random pulses and door activity.
        repeat (4000) begin
            reset  = ($urandom % 512) == 0;
            cancel = ($urandom % 64) == 0;
            pause  = ($urandom % 16) == 0;
            start  = ($urandom % 6) == 0;
            if (door_open) door_open = ($urandom % 4) != 0;
            else           door_open = ($urandom % 48) == 0;
            time_in  = TB'($urandom % 5);
            level_in = 2'($urandom % 4);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
